// File: rtl/nash_pkg.sv
// Shared types and helpers for the Nash receive path: FSM state encoding,
// default geometry and the single cyclic Rule-30 generation.
package nash_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVOLVE = 2'd1,
        DONE   = 2'd2
    } nash_state_e;

    localparam int NASH_N_DEF = 128;
    localparam int NASH_D_DEF = 256;
    localparam int R30_MAX_N  = 1024;

    // Operates on a zero-padded vector so one function serves every width;
    // only the low n bits are meaningful and the rest come back zero.
    function automatic logic [R30_MAX_N-1:0] r30_step(
        input logic [R30_MAX_N-1:0] s,
        input int                   n
    );
        logic [R30_MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < R30_MAX_N; i++) begin
            if (i < n) begin
                r[i] = s[(i + 1) % n] ^ (s[i] | s[(i + n - 1) % n]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nash_receiver_evolve.sv
// Combinational chain of S cyclic Rule-30 generations over an N-bit state.
module r30_evolve
    import nash_pkg::*;
#(
    parameter int N = NASH_N_DEF,
    parameter int S = 1
) (
    input  logic [N-1:0] state_i,
    output logic [N-1:0] state_o
);

    logic [N-1:0] stage [S+1];

    assign stage[0] = state_i;

    for (genvar k = 0; k < S; k++) begin : g_step
        assign stage[k+1] = N'(r30_step(R30_MAX_N'(stage[k]), N));
    end

    assign state_o = stage[S];

endmodule

// File: rtl/nash_receiver.sv
// Nash receiver: regenerates the Rule-30 keystream and XORs it onto the ciphertext.
// Optional macro NASH_RX_CHAIN_EN seeds each block from the previous ciphertext.
module nash_receiver
    import nash_pkg::*;
#(
    parameter int N = NASH_N_DEF,
    parameter int D = NASH_D_DEF,
    parameter int S = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_ct,
    input  logic [N-1:0] in_seed,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_pt,
    output logic [N-1:0] feedback,
    output logic         busy
);

    localparam int CW = $clog2(D + 1);

    if (S < 1 || D < 1 || (D % S) != 0 || N < 1 || N > R30_MAX_N) begin : g_param_check
        $error("nash_receiver: D must be >= 1 and a multiple of S, N within range");
    end

    nash_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  ca_q, ca_d;
    logic [N-1:0]  ct_q, ct_d;
    logic [N-1:0]  fb_q, fb_d;
    logic [N-1:0]  pt_q, pt_d;
    logic [N-1:0]  ca_next;
    logic [N-1:0]  seed_sel;
    logic          accept;
    logic          last_step;

    r30_evolve #(.N(N), .S(S)) u_evolve (
        .state_i (ca_q),
        .state_o (ca_next)
    );

    assign accept    = in_valid && in_ready;
    assign last_step = (int'(cnt_q) + S) == D;

`ifdef NASH_RX_CHAIN_EN
    // Tracks whether any block arrived since reset; until then there is no
    // previous ciphertext to chain from.
    logic has_q, has_d;

    assign has_d    = has_q | accept;
    assign seed_sel = (in_first || !has_q) ? in_seed : fb_q;

    always_ff @(posedge clk) begin
        if (rst) has_q <= 1'b0;
        else     has_q <= has_d;
    end
`else
    logic unused_first;

    assign unused_first = in_first;
    assign seed_sel     = in_seed;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ca_q    <= '0;
            ct_q    <= '0;
            fb_q    <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ca_q    <= ca_d;
            ct_q    <= ct_d;
            fb_q    <= fb_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ca_d    = ca_q;
        ct_d    = ct_q;
        fb_d    = fb_q;
        pt_d    = pt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ct_d    = in_ct;
                    fb_d    = in_ct;
                    ca_d    = seed_sel;
                    cnt_d   = '0;
                    state_d = EVOLVE;
                end
            end
            EVOLVE: begin
                ca_d  = ca_next;
                cnt_d = cnt_q + CW'(S);
                if (last_step) begin
                    pt_d    = ct_q ^ ca_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        busy      = (state_q == EVOLVE) || (state_q == DONE);
    end

    assign out_pt   = pt_q;
    assign feedback = fb_q;

endmodule
